// File: rtl/renas_write_buffer.sv
// rtl/renas_write_buffer.sv - coalescing word write buffer draining to renas_memory
module renas_write_buffer #(
    parameter int DATA_LENGTH = 32,
    parameter int BYTE_OFFSET = 2,
    parameter int WB_DEPTH    = 4
) (
    input  logic                                 cache_clk,
    input  logic                                 rst_n,
    input  logic                                 wr_valid,
    input  logic [DATA_LENGTH-1:0]               wr_addr,
    input  logic [DATA_LENGTH-1:0]               wr_data,
    output logic                                 wr_ready,
    input  logic [DATA_LENGTH-1:0]               rd_addr,
    output logic                                 fwd_hit,
    output logic [DATA_LENGTH-1:0]               fwd_data,
    input  logic                                 flush_req,
    output logic                                 flush_done,
    output logic                                 empty,
    output logic [2*DATA_LENGTH-BYTE_OFFSET-1:0] wb_data,
    output logic                                 wb_req,
    input  logic                                 wb_ack,
    input  logic                                 full_flag
);
    localparam int PW = DATA_LENGTH - BYTE_OFFSET;
    localparam int AW = $clog2(WB_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    logic [PW-1:0]          ptr_q  [WB_DEPTH];
    logic [PW-1:0]          ptr_d  [WB_DEPTH];
    logic [DATA_LENGTH-1:0] data_q [WB_DEPTH];
    logic [DATA_LENGTH-1:0] data_d [WB_DEPTH];
    logic [AW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    state_t                 state_q, state_d;
    logic                   wb_req_q, wb_req_d;
    logic                   flush_done_q, flush_done_d;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] scan_idx, coal_idx;
    logic          coal_hit, accept, push, pop;
    logic          unused_low_bits;

    assign wr_ptr = wr_addr[DATA_LENGTH-1:BYTE_OFFSET];
    assign rd_ptr = rd_addr[DATA_LENGTH-1:BYTE_OFFSET];
    assign unused_low_bits = ^{wr_addr[BYTE_OFFSET-1:0], rd_addr[BYTE_OFFSET-1:0]};

    // Scan oldest to youngest so the last match found is the youngest one.
    // The head is not a coalesce target once its transfer has started.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        coal_hit = 1'b0;
        coal_idx = '0;
        scan_idx = head_q;
        for (int k = 0; k < WB_DEPTH; k++) begin
            scan_idx = head_q + AW'(k);
            if (CW'(k) < count_q) begin
                if (ptr_q[scan_idx] == rd_ptr) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[scan_idx];
                end
                if ((ptr_q[scan_idx] == wr_ptr) && !((k == 0) && (state_q != S_IDLE))) begin
                    coal_hit = 1'b1;
                    coal_idx = scan_idx;
                end
            end
        end
    end

    assign wr_ready = (count_q < CW'(WB_DEPTH)) | coal_hit;
    assign accept   = wr_valid & wr_ready;
    assign push     = accept & ~coal_hit;
    assign pop      = (state_q == S_REQ) & wb_ack;

    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        if (accept && coal_hit) begin
            data_d[coal_idx] = wr_data;
        end
        if (push) begin
            ptr_d[tail_q]  = wr_ptr;
            data_d[tail_q] = wr_data;
        end
        tail_d = push ? tail_q + 1'b1 : tail_q;
        head_d = pop ? head_q + 1'b1 : head_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wb_req_d     = wb_req_q;
        flush_done_d = flush_req & (count_q == '0) & (state_q == S_IDLE);
        case (state_q)
            S_IDLE: if ((count_q != '0) && !full_flag && !wb_ack) begin
                state_d  = S_REQ;
                wb_req_d = 1'b1;
            end
            S_REQ: if (wb_ack) begin
                state_d  = S_WAIT;
                wb_req_d = 1'b0;
            end
            S_WAIT: if (!wb_ack && !full_flag) begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                wb_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge cache_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                ptr_q[i]  <= '0;
                data_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            wb_req_q     <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            data_q       <= data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            wb_req_q     <= wb_req_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign wb_data    = {data_q[head_q], ptr_q[head_q]};
    assign wb_req     = wb_req_q;
    assign flush_done = flush_done_q;
    assign empty      = (count_q == '0);
endmodule
